sp_ctrl_regs: RTL and testbench

SP_CTRL_REGS -- requirements
Module: sp_ctrl_regs

---
 rtl/sp_ctrl_pkg.sv | 56 +++++
 rtl/sp_ctrl_regs.sv | 201 ++++++++++++++++++++
 tb/tb_sp_ctrl_regs.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ctrl_pkg
//  Description : Shared definitions for the scratchpad control register block.
//                Holds the register address map, STATUS bit positions, the
//                control FSM state type, the default dimension limits, and
//                the helpers that merge byte lanes and check GEMM dimensions.
//  Revision    : 1.0 - initial release
// ============================================================================
package sp_ctrl_pkg;

   // Register byte addresses (full 32-bit compare)
   localparam logic [31:0] ADDR_CTRL   = 32'h0000_0000;
   localparam logic [31:0] ADDR_MODE   = 32'h0000_0004;
   localparam logic [31:0] ADDR_M      = 32'h0000_0008;
   localparam logic [31:0] ADDR_K      = 32'h0000_000C;
   localparam logic [31:0] ADDR_N      = 32'h0000_0010;
   localparam logic [31:0] ADDR_STATUS = 32'h0000_0064;

   // STATUS bit positions
   localparam int unsigned ST_DONE = 0;
   localparam int unsigned ST_BUSY = 1;
   localparam int unsigned ST_ERR  = 2;

   // Default dimension limits
   localparam int unsigned DEF_MAX_DIM   = 64;
   localparam int unsigned DEF_DIM_ALIGN = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Replace only the byte lanes whose write enable is set.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  web);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (web[i]) res[8*i +: 8] = new_v[8*i +: 8];
      end
      return res;
   endfunction

   // A dimension is legal when nonzero, a multiple of the array edge and
   // no larger than the largest supported size.
   function automatic logic dim_valid(input logic [31:0] d,
                                      input int unsigned max_dim,
                                      input int unsigned align);
      return (d != 32'd0) && ((d % align) == 32'd0) && (d <= max_dim);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ctrl_regs.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ctrl_regs
//  Description : Host-visible control registers and launch FSM for a
//                systolic GEMM engine. The host programs MODE/M/K/N and raises
//                CTRL.start; legal dimensions launch the engine with a single
//                cycle pulse, illegal ones flag STATUS.err.
//  Ports       : clk          - clock, all state on rising edge
//                reset        - asynchronous active-low reset
//                sp_addr      - host byte address
//                sp_data_in   - host write data
//                sp_web       - per-byte write enables
//                sp_data_out  - registered read data (1-cycle latency)
//                eng_start    - one-cycle launch pulse
//                eng_mode     - 0 = WS, 1 = OS (latched at launch)
//                eng_m/k/n    - latched dimensions
//                eng_done     - one-cycle completion pulse from engine
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_ctrl_regs
   import sp_ctrl_pkg::*;
#(
   parameter int unsigned MAX_DIM   = DEF_MAX_DIM,
   parameter int unsigned DIM_ALIGN = DEF_DIM_ALIGN
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] sp_addr,
   input  logic [31:0] sp_data_in,
   input  logic [3:0]  sp_web,
   output logic [31:0] sp_data_out,
   output logic        eng_start,
   output logic        eng_mode,
   output logic [31:0] eng_m,
   output logic [31:0] eng_k,
   output logic [31:0] eng_n,
   input  logic        eng_done
);

   state_t      r_state, w_state_nxt;
   logic        r_start, w_start_nxt;
   logic        r_mode,  w_mode_nxt;
   logic [31:0] r_m, r_k, r_n;
   logic [31:0] w_m_nxt, w_k_nxt, w_n_nxt;
   logic        r_done, r_busy, r_err;
   logic        w_done_nxt, w_busy_nxt, w_err_nxt;
   logic        w_launch;
   logic [31:0] w_rdata;

   logic        r_eng_start, r_eng_mode;
   logic [31:0] r_eng_m, r_eng_k, r_eng_n, r_rdata;

   logic w_wr_any, w_wr_ctrl, w_wr_mode, w_wr_m, w_wr_k, w_wr_n, w_wr_status;
   logic w_clr, w_ctrl_bit, w_mode_bit, w_dims_ok;

   assign w_wr_any    = |sp_web;
   assign w_wr_ctrl   = w_wr_any && (sp_addr == ADDR_CTRL);
   assign w_wr_mode   = w_wr_any && (sp_addr == ADDR_MODE);
   assign w_wr_m      = w_wr_any && (sp_addr == ADDR_M);
   assign w_wr_k      = w_wr_any && (sp_addr == ADDR_K);
   assign w_wr_n      = w_wr_any && (sp_addr == ADDR_N);
   assign w_wr_status = w_wr_any && (sp_addr == ADDR_STATUS);

   // A STATUS clear is any enabled write whose bit0 data is 0.
   assign w_clr      = w_wr_status && !sp_data_in[0];
   // CTRL and MODE keep only bit0, which lives in byte lane 0.
   assign w_ctrl_bit = sp_web[0] ? sp_data_in[0] : r_start;
   assign w_mode_bit = sp_web[0] ? sp_data_in[0] : r_mode;
   assign w_dims_ok  = dim_valid(r_m, MAX_DIM, DIM_ALIGN) &&
                       dim_valid(r_k, MAX_DIM, DIM_ALIGN) &&
                       dim_valid(r_n, MAX_DIM, DIM_ALIGN);

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and register-update logic
   always_comb begin
      w_state_nxt = r_state;
      w_start_nxt = r_start;
      w_mode_nxt  = r_mode;
      w_m_nxt     = r_m;
      w_k_nxt     = r_k;
      w_n_nxt     = r_n;
      w_done_nxt  = r_done;
      w_busy_nxt  = r_busy;
      w_err_nxt   = r_err;
      w_launch    = 1'b0;

      // Configuration is frozen only while the engine runs.
      if (r_state != S_RUN) begin
         if (w_wr_ctrl) w_start_nxt = w_ctrl_bit;
         if (w_wr_mode) w_mode_nxt  = w_mode_bit;
         if (w_wr_m)    w_m_nxt     = byte_merge(r_m, sp_data_in, sp_web);
         if (w_wr_k)    w_k_nxt     = byte_merge(r_k, sp_data_in, sp_web);
         if (w_wr_n)    w_n_nxt     = byte_merge(r_n, sp_data_in, sp_web);
      end

      unique case (r_state)
         S_IDLE: begin
            // Only a 0->1 change of the stored start bit launches; dims
            // cannot change in the same cycle since only one address is hit.
            if (w_wr_ctrl && !r_start && w_ctrl_bit) begin
               if (w_dims_ok) begin
                  w_launch    = 1'b1;
                  w_busy_nxt  = 1'b1;
                  w_state_nxt = S_RUN;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
            if (w_clr && r_err) begin
               w_err_nxt   = 1'b0;
               w_start_nxt = 1'b0;
            end
         end
         S_RUN: begin
            // A clear in the same cycle as eng_done is deliberately dropped.
            if (eng_done) begin
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (w_clr) begin
               w_done_nxt  = 1'b0;
               w_err_nxt   = 1'b0;
               w_start_nxt = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Read mux uses post-update values so read-during-write sees new data.
   always_comb begin
      w_rdata = 32'd0;
      unique case (sp_addr)
         ADDR_CTRL:   w_rdata = {31'd0, w_start_nxt};
         ADDR_MODE:   w_rdata = {31'd0, w_mode_nxt};
         ADDR_M:      w_rdata = w_m_nxt;
         ADDR_K:      w_rdata = w_k_nxt;
         ADDR_N:      w_rdata = w_n_nxt;
         ADDR_STATUS: begin
            w_rdata[ST_DONE] = w_done_nxt;
            w_rdata[ST_BUSY] = w_busy_nxt;
            w_rdata[ST_ERR]  = w_err_nxt;
         end
         default:     w_rdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_start     <= 1'b0;
         r_mode      <= 1'b0;
         r_m         <= 32'd0;
         r_k         <= 32'd0;
         r_n         <= 32'd0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_eng_start <= 1'b0;
         r_eng_mode  <= 1'b0;
         r_eng_m     <= 32'd0;
         r_eng_k     <= 32'd0;
         r_eng_n     <= 32'd0;
         r_rdata     <= 32'd0;
      end else begin
         r_start     <= w_start_nxt;
         r_mode      <= w_mode_nxt;
         r_m         <= w_m_nxt;
         r_k         <= w_k_nxt;
         r_n         <= w_n_nxt;
         r_done      <= w_done_nxt;
         r_busy      <= w_busy_nxt;
         r_err       <= w_err_nxt;
         r_eng_start <= w_launch;
         r_rdata     <= w_rdata;
         if (w_launch) begin
            r_eng_mode <= r_mode;
            r_eng_m    <= r_m;
            r_eng_k    <= r_k;
            r_eng_n    <= r_n;
         end
      end
   end

   assign sp_data_out = r_rdata;
   assign eng_start   = r_eng_start;
   assign eng_mode    = r_eng_mode;
   assign eng_m       = r_eng_m;
   assign eng_k       = r_eng_k;
   assign eng_n       = r_eng_n;

endmodule
`default_nettype wire

// File: tb/tb_sp_ctrl_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sp_ctrl_regs
//  Description : Scoreboard bench for sp_ctrl_regs. Each driven cycle runs a
//                behavioural model of the register block and queues the
//                expected read data and engine outputs; a monitor pops one
//                entry after every clock edge and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ctrl_regs;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] sp_addr = '0;
   logic [31:0] sp_data_in = '0;
   logic [3:0]  sp_web = '0;
   logic [31:0] sp_data_out;
   logic        eng_start, eng_mode, eng_done = 1'b0;
   logic [31:0] eng_m, eng_k, eng_n;

   sp_ctrl_regs dut (
      .clk        (clk),
      .reset      (reset),
      .sp_addr    (sp_addr),
      .sp_data_in (sp_data_in),
      .sp_web     (sp_web),
      .sp_data_out(sp_data_out),
      .eng_start  (eng_start),
      .eng_mode   (eng_mode),
      .eng_m      (eng_m),
      .eng_k      (eng_k),
      .eng_n      (eng_n),
      .eng_done   (eng_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] rd;
      logic        start;
      logic        mode;
      logic [31:0] dm, dk, dn;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   // ---------------- behavioural model ----------------
   typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;
   mstate_t     m_state;
   bit          m_start, m_mode, m_done, m_busy, m_err;
   logic [31:0] m_dim [3];
   bit          m_eng_mode;
   logic [31:0] m_eng_dim [3];

   function automatic bit dim_ok(logic [31:0] d);
      return (d != 0) && (d % 8 == 0) && (d <= 64);
   endfunction

   task automatic model_reset();
      m_state = M_IDLE;
      m_start = 0; m_mode = 0; m_done = 0; m_busy = 0; m_err = 0;
      m_eng_mode = 0;
      for (int i = 0; i < 3; i++) begin
         m_dim[i] = 0;
         m_eng_dim[i] = 0;
      end
   endtask

   function automatic logic [31:0] model_read(logic [31:0] a);
      case (a)
         32'h00:  return {31'd0, m_start};
         32'h04:  return {31'd0, m_mode};
         32'h08:  return m_dim[0];
         32'h0C:  return m_dim[1];
         32'h10:  return m_dim[2];
         32'h64:  return {29'd0, m_err, m_busy, m_done};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_step(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] w, input logic dn,
                             output exp_t e);
      bit wr, launch, new_start;
      int idx;
      wr = (w != 0);
      launch = 0;
      idx = (a == 32'h08) ? 0 : (a == 32'h0C) ? 1 : (a == 32'h10) ? 2 : -1;
      if (m_state == M_RUN) begin
         if (dn) begin
            m_done = 1; m_busy = 0; m_state = M_DONE;
         end
      end else begin
         if (wr && idx >= 0)
            for (int b = 0; b < 4; b++)
               if (w[b]) m_dim[idx][8*b +: 8] = d[8*b +: 8];
         if (wr && a == 32'h04 && w[0]) m_mode = d[0];
         if (wr && a == 32'h00) begin
            new_start = w[0] ? d[0] : m_start;
            if (m_state == M_IDLE && !m_start && new_start) begin
               if (dim_ok(m_dim[0]) && dim_ok(m_dim[1]) && dim_ok(m_dim[2])) begin
                  launch = 1;
                  m_busy = 1;
                  m_state = M_RUN;
                  m_eng_mode = m_mode;
                  for (int i = 0; i < 3; i++) m_eng_dim[i] = m_dim[i];
               end else begin
                  m_err = 1;
               end
            end
            m_start = new_start;
         end
         if (wr && a == 32'h64 && !d[0]) begin
            if (m_state == M_DONE) begin
               m_done = 0; m_err = 0; m_start = 0; m_state = M_IDLE;
            end else if (m_err) begin
               m_err = 0; m_start = 0;
            end
         end
      end
      e.rd    = model_read(a);
      e.start = launch;
      e.mode  = m_eng_mode;
      e.dm    = m_eng_dim[0];
      e.dk    = m_eng_dim[1];
      e.dn    = m_eng_dim[2];
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("sp_data_out", sp_data_out, mon_e.rd);
         check("eng_start", {31'd0, eng_start}, {31'd0, mon_e.start});
         check("eng_mode", {31'd0, eng_mode}, {31'd0, mon_e.mode});
         check("eng_m", eng_m, mon_e.dm);
         check("eng_k", eng_k, mon_e.dk);
         check("eng_n", eng_n, mon_e.dn);
      end
   end

   task automatic check_reset_outputs();
      check("rst sp_data_out", sp_data_out, 32'd0);
      check("rst eng_start", {31'd0, eng_start}, 32'd0);
      check("rst eng_mode", {31'd0, eng_mode}, 32'd0);
      check("rst eng_m", eng_m, 32'd0);
      check("rst eng_k", eng_k, 32'd0);
      check("rst eng_n", eng_n, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   task automatic step(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] w, input logic dn);
      exp_t e;
      @(negedge clk);
      sp_addr = a; sp_data_in = d; sp_web = w; eng_done = dn;
      model_step(a, d, w, dn, e);
      exp_q.push_back(e);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      step(a, d, 4'hF, 1'b0);
   endtask

   task automatic rd(input logic [31:0] a);
      step(a, 32'd0, 4'h0, 1'b0);
   endtask

   task automatic mid_cycle_reset();
      @(negedge clk);
      sp_web = 0; eng_done = 0; sp_addr = 32'h64;
      #2 reset = 1'b0;
      #1 check_reset_outputs();
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs();
      reset = 1'b1;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [31:0] a, d, pick;
      logic [3:0]  w;
      logic        dn;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs();
      reset = 1'b1;

      // Launch with legal dims, CTRL held at 1 for several cycles
      wr(32'h04, 1); wr(32'h08, 40); wr(32'h0C, 40); wr(32'h10, 40);
      repeat (5) wr(32'h00, 1);
      rd(32'h64);
      repeat (20) rd(32'h64);
      step(32'h64, 0, 4'h0, 1'b1);
      rd(32'h64); rd(32'h64);
      wr(32'h64, 0);
      rd(32'h64);

      // Unaligned M flags err; clear; retry with a legal M
      wr(32'h08, 37); wr(32'h00, 1); rd(32'h64);
      wr(32'h64, 0); rd(32'h64); rd(32'h00);
      wr(32'h08, 40); wr(32'h00, 1); rd(32'h64);

      // Config writes ignored while running
      wr(32'h08, 8); rd(32'h08);
      wr(32'h04, 0); rd(32'h04);

      // eng_done coincident with a STATUS clear write
      step(32'h64, 0, 4'hF, 1'b1);
      rd(32'h64);
      wr(32'h64, 0); rd(32'h64);

      // Relaunch, then reset mid-run
      wr(32'h00, 1); rd(32'h64);
      mid_cycle_reset();
      repeat (4) rd(32'h64);
      rd(32'h00);

      // Byte-lane write and an unmapped read
      step(32'h10, 32'hFFFF_FF10, 4'b0001, 1'b0);
      rd(32'h10);
      rd(32'h20);

      // Randomised traffic
      for (int it = 0; it < 600; it++) begin
         pick = $urandom_range(0, 7);
         case (pick)
            0: a = 32'h00;  1: a = 32'h04;  2: a = 32'h08;  3: a = 32'h0C;
            4: a = 32'h10;  5: a = 32'h64;  6: a = 32'h20;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: d = 0;   1: d = 8;   2: d = 16;  3: d = 37;
            4: d = 40;  5: d = 64;  6: d = 72;
            default: d = $urandom;
         endcase
         if (a == 32'h00 || a == 32'h04) d = {$urandom_range(0, 1) == 0 ? 31'd0 : 31'($urandom), 1'($urandom_range(0, 1))};
         if (a == 32'h64) d = {31'($urandom), 1'($urandom_range(0, 3) == 0)};
         w  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
         dn = (m_state == M_RUN) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
         step(a, d, w, dn);
         if ($urandom_range(0, 199) == 0) mid_cycle_reset();
      end

      @(negedge clk);
      sp_web = 0; eng_done = 0;
      @(posedge clk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
